// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: a fetch port (I) and a data port (D) share one
// memory with a fixed access length of LAT cycles and fair round-robin on ties.
module mem_arbiter #(
   parameter int unsigned LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        IReq,
   input  logic [15:0] IAddr,
   input  logic        Halt,
   input  logic        DReq,
   input  logic        DWr,
   input  logic [15:0] DAddr,
   input  logic [15:0] DWData,
   input  logic [15:0] MemRData,
   output logic [15:0] IData,
   output logic        IDone,
   output logic        IStall,
   output logic [15:0] DRData,
   output logic        DDone,
   output logic        DStall,
   output logic        MemEn,
   output logic        MemWr,
   output logic [15:0] MemAddr,
   output logic [15:0] MemWData,
   output logic        err
);

   localparam int unsigned CW = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            last_grant;   // 1 = data port was granted most recently
   logic            wr_q;

   logic            cand_i;
   logic            cand_d;
   logic            blocked;
   logic            grant_i;
   logic            grant_d;
   logic [15:0]     grant_addr;

   // Grant selection: data wins unless both compete and data went last.
   assign cand_i     = IReq & ~Halt;
   assign cand_d     = DReq;
   assign blocked    = IDone | DDone;
   assign grant_d    = (state == IDLE) & ~blocked & cand_d & (~cand_i | ~last_grant);
   assign grant_i    = (state == IDLE) & ~blocked & cand_i & (~cand_d | last_grant);
   assign grant_addr = grant_d ? DAddr : IAddr;

   assign IStall = IReq & ~IDone;
   assign DStall = DReq & ~DDone;

   // Arbiter FSM with registered memory strobes, data capture and done pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         last_grant <= 1'b0;
         wr_q       <= 1'b0;
         MemEn      <= 1'b0;
         MemWr      <= 1'b0;
         MemAddr    <= 16'h0000;
         MemWData   <= 16'h0000;
         IData      <= 16'h0000;
         DRData     <= 16'h0000;
         IDone      <= 1'b0;
         DDone      <= 1'b0;
         err        <= 1'b0;
      end else begin
         IDone <= 1'b0;
         DDone <= 1'b0;
         err   <= 1'b0;
         case (state)
            IDLE: begin
               MemEn <= 1'b0;
               MemWr <= 1'b0;
               if (grant_d | grant_i) begin
                  last_grant <= grant_d;
                  MemAddr    <= grant_addr;
                  if (grant_d) begin
                     MemWData <= DWData;
                     wr_q     <= DWr;
                  end else begin
                     wr_q     <= 1'b0;
                  end
                  // Odd addresses never reach memory; complete at once with zero data.
                  if (grant_addr[0]) begin
                     err <= 1'b1;
                     if (grant_d) begin
                        DDone  <= 1'b1;
                        DRData <= 16'h0000;
                     end else begin
                        IDone  <= 1'b1;
                        IData  <= 16'h0000;
                     end
                  end else begin
                     cnt   <= CW'(LAT - 1);
                     MemEn <= 1'b1;
                     MemWr <= grant_d & DWr;
                     state <= grant_d ? BUSY_D : BUSY_I;
                  end
               end
            end
            BUSY_I, BUSY_D: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else begin
                  MemEn <= 1'b0;
                  MemWr <= 1'b0;
                  state <= IDLE;
                  if (state == BUSY_I) begin
                     IData <= MemRData;
                     IDone <= 1'b1;
                  end else begin
                     if (!wr_q) begin
                        DRData <= MemRData;
                     end
                     DDone <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               MemEn <= 1'b0;
               MemWr <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LAT, default 2, memory access length in cycles; legal range 1..7.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 IReq  in  1  fetch read request; held with IAddr stable until IDone.
REQ-005 IAddr  in  16  fetch byte address.
REQ-006 Halt  in  1  blocks new fetch grants while 1.
REQ-007 DReq  in  1  data request; held with DWr, DAddr and DWData stable until DDone.
REQ-008 DWr  in  1  1 = write, 0 = read.
REQ-009 DAddr  in  16  data byte address.
REQ-010 DWData  in  16  write data.
REQ-011 MemRData  in  16  memory read data, valid in the last cycle of an access.
REQ-012 IData  out  16  registered fetched instruction.
REQ-013 IDone  out  1  one-cycle fetch completion pulse.
REQ-014 IStall  out  1  IReq & ~IDone, combinational.
REQ-015 DRData  out  16  registered load data.
REQ-016 DDone  out  1  one-cycle data completion pulse.
REQ-017 DStall  out  1  DReq & ~DDone, combinational.
REQ-018 MemEn, MemWr  out  1 each  memory enable and write strobe.
REQ-019 MemAddr, MemWData  out  16 each  latched address and write data.
REQ-020 err  out  1  one-cycle unaligned-access pulse.

Function
REQ-021 The FSM SHALL have three states: IDLE, BUSY_I and BUSY_D.
REQ-022 IDLE grant candidates: D when DReq=1; I when IReq=1 and Halt=0.
REQ-023 No grant SHALL be made in a cycle where IDone or DDone is 1.
REQ-024 Tie (both candidates) SHALL go to the requester not granted last; the last_grant register records the most recent grant.
REQ-025 Grant SHALL latch address, write data and write flag; next state SHALL be BUSY_I or BUSY_D.
REQ-026 A down-counter SHALL load LAT-1 on grant and decrement each BUSY cycle.
REQ-027 MemEn=1 SHALL hold for exactly LAT cycles, with MemAddr and MemWData driven from latches.
REQ-028 MemWr SHALL equal the latched DWr in BUSY_D and SHALL be 0 in BUSY_I and IDLE.
REQ-029 In the BUSY cycle with counter=0, a read SHALL capture MemRData into IData or DRData, and the next state SHALL be IDLE.
REQ-030 Done SHALL pulse in the cycle after capture, so grant-to-Done latency is LAT+1 cycles and the minimum spacing between grants is LAT+2 cycles.
REQ-031 A write SHALL leave DRData unchanged and SHALL pulse DDone with the same timing as a read.
REQ-032 An unaligned access (latched addr[0]=1) SHALL make no memory access: next state IDLE; in the following cycle err=1 and the requester's Done=1; its data register loads 16'h0000; last_grant updates.
REQ-033 Halt rising during BUSY_I SHALL NOT abort the fetch in progress.
REQ-034 Requests arriving while BUSY SHALL wait; the requester sees Stall=1 until its own Done.
REQ-035 At most one of IDone, DDone SHALL be 1 in any cycle.
REQ-036 MemEn=0 SHALL hold in IDLE.

Reset
REQ-037 rst=1 SHALL immediately force: state IDLE; counter 0; last_grant=I; MemEn, MemWr, IDone, DDone and err to 0; IData, DRData, MemAddr and MemWData to 16'h0000.
REQ-038 rst asserted mid-access SHALL abort the access with no Done pulse; on release the arbiter SHALL accept requests from the first clk edge.

Verification (LAT=2)
REQ-039 Fetch: IReq=1, IAddr=16'h0010, grant at edge 0 -> MemEn=1 in cycles 1-2; IData=MemRData and IDone=1 in cycle 3.
REQ-040 Tie: IReq=DReq=1 out of reset -> D served first, then I, with grants 4 cycles apart; alternation SHALL repeat if both requests are held.
REQ-041 Store: DReq=1, DWr=1, DAddr=16'h0100, DWData=16'hBEEF -> MemWr=1 for 2 cycles; DDone pulse; DRData unchanged.
REQ-042 Halt=1 with IReq=1 -> no MemEn and IStall stays 1; Halt=0 -> fetch proceeds normally.
REQ-043 DAddr=16'h0101 -> no MemEn; err=1 and DDone=1 in the same cycle; DRData=16'h0000.
REQ-044 rst pulsed in cycle 1 of a fetch -> MemEn drops without waiting for a clock edge; no IDone; the same IReq is re-served after reset.
